ahb_req_arbiter: RTL and testbench
==================================

// Module: ahb_req_arbiter
// PURPOSE
//  Shares one AHB-Lite master port between NREQ local requesters driving the dut slave via ahb_if.
//  Round-robin arbitration; issues one SINGLE, NONSEQ transfer at a time (non-pipelined).
//  Sits in top_th between the requester agents and ahb_if; response is returned to the granted requester.
// PARAMETERS
//  NREQ  4   number of requesters (2..8)
//  AW    32  HADDR width
//  DW    32  HWDATA/HRDATA width
// PORTS
//  clk        in   1        system clock; all logic on posedge
//  rstn       in   1        asynchronous active-low reset
//  req_valid  in   NREQ     request pending, one bit per requester
//  req_ready  out  NREQ     one-hot accept; transfer taken when valid&ready
//  req_write  in   NREQ     1=write, 0=read, per requester
//  req_addr   in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//  req_wdata  in   NREQ*DW  packed write data
//  req_size   in   NREQ*3   packed HSIZE
//  rsp_valid  out  NREQ     one-hot 1-cycle completion pulse
//  rsp_rdata  out  DW       read data, valid with rsp_valid
//  rsp_err    out  1        HRESP=ERROR seen, valid with rsp_valid
//  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA  out  AHB-Lite master
//  HREADYOUT, HRESP, HRDATA  in  AHB-Lite slave response (HREADYOUT used as HREADY)
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE, HTRANS=IDLE(2'b00), HSEL=0, HADDR/HWDATA/HWRITE/HSIZE=0,
//   req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rr pointer=NREQ-1 (req 0 wins first).
//  Constants: HBURST=3'b000 SINGLE, HPROT=4'b0011, HMASTLOCK=0 at all times.
//  FSM IDLE->ADDR->DATA->IDLE:
//   IDLE: req_ready is combinational one-hot of winner = first valid bit searching from rr+1, wrapping
//    at NREQ-1 -> 0; none valid -> req_ready=0, stay. On accept (cycle T) register addr/write/size/wdata,
//    owner index, rr<=owner, go ADDR.
//   ADDR (T+1): HSEL=1, HTRANS=NONSEQ(2'b10), HADDR/HWRITE/HSIZE from captured request. Held until
//    HREADYOUT=1 sampled, then go DATA.
//   DATA: HTRANS=IDLE, HSEL=0, HWDATA=captured wdata (held stable through wait states).
//    HREADYOUT=0 -> stay (wait state). HREADYOUT=1 -> rsp_valid[owner]=1 next cycle, rsp_rdata=HRDATA
//    (reads; 0 for writes), rsp_err=HRESP; go IDLE.
//  Minimum latency accept->rsp_valid: 3 cycles (ADDR 1, DATA 1, rsp registered).
//  Error: first ERROR cycle (HRESP=1, HREADYOUT=0) is a wait state; completion on the second cycle
//   (HRESP=1, HREADYOUT=1) with rsp_err=1. No retry, no cancel needed (single transfer).
//  req_ready is 0 in ADDR/DATA; new requests wait. req_valid drop before accept: no effect.
//  Simultaneous rsp pulse and new accept allowed: IDLE reached in same cycle rsp is registered.
//  Width rules: req_size is passed through; no alignment check (slave responds ERROR if unsupported).
//  rstn low mid-transfer: everything returns to reset values immediately; no rsp_valid for the
//   aborted transfer; rr pointer re-initialised.
// STRUCTURE
//  ahb_arb_pkg: htrans_t (IDLE/BUSY/NONSEQ/SEQ), hburst SINGLE, HPROT_DEFAULT, arb_state_t {IDLE,ADDR,DATA}.
//  Sub-module rr_arbiter (NREQ, req vector + rr pointer in, one-hot grant + index out), combinational.
//  Top holds FSM, capture registers, AHB output registers, response registers.
// TESTING
//  1 req0 write 0x100 data 0xDEADBEEF, HREADYOUT=1 -> HTRANS=2'b10 HADDR=0x100 one cycle, then
//    HWDATA=0xDEADBEEF, rsp_valid[0] 3 cycles after accept, rsp_err=0.
//  2 req0..req3 valid together, repeated -> grant order 0,1,2,3,0; req2 only re-requesting after
//    its grant with req1 also valid -> req1 granted first? no: next after 2 is 3, then 0, then 1.
//  3 read 0x200, slave HREADYOUT=0 for 3 DATA cycles then HRDATA=0x12345678 -> HWDATA/HADDR stable,
//    rsp_valid at accept+6, rsp_rdata=0x12345678.
//  4 write, slave two-cycle ERROR -> rsp_err=1 with rsp_valid, next request served normally.
//  5 rstn=0 during DATA wait state -> HTRANS=0, HSEL=0, rsp_valid never pulses; after release req0 wins.
//  6 idle bus, no req_valid for 20 cycles -> HTRANS=IDLE, HSEL=0, req_ready=0 throughout.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: AHB-Lite encodings and arbiter FSM states shared by the request arbiter.
package ahb_arb_pkg;
   typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_t;
   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} arb_state_t;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [3:0] HPROT_DEFAULT = 4'b0011;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr+1 with wrap.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            any
);
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!any && req[(int'(ptr) + k) % NREQ]) begin
            any = 1'b1;
            gnt[(int'(ptr) + k) % NREQ] = 1'b1;
            idx = IW'((int'(ptr) + k) % NREQ);
         end
      end
   end
endmodule

// File: rtl/ahb_req_arbiter.sv
// ahb_req_arbiter: shares one AHB-Lite master port between NREQ requesters, one SINGLE NONSEQ
// transfer at a time, with round-robin selection and the response routed back to the owner.
module ahb_req_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int AW   = 32,
   parameter int DW   = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [NREQ-1:0]  req_valid,
   output logic [NREQ-1:0]  req_ready,
   input  logic [NREQ-1:0]  req_write,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   input  logic [NREQ*3-1:0] req_size,
   output logic [NREQ-1:0]  rsp_valid,
   output logic [DW-1:0]    rsp_rdata,
   output logic             rsp_err,
   output logic             HSEL,
   output logic [AW-1:0]    HADDR,
   output logic             HWRITE,
   output logic [2:0]       HSIZE,
   output logic [2:0]       HBURST,
   output logic [3:0]       HPROT,
   output logic [1:0]       HTRANS,
   output logic             HMASTLOCK,
   output logic [DW-1:0]    HWDATA,
   input  logic             HREADYOUT,
   input  logic             HRESP,
   input  logic [DW-1:0]    HRDATA
);
   localparam int IW = $clog2(NREQ);
   arb_state_t state, state_nxt;
   logic [IW-1:0] rr, owner, win_idx;
   logic [NREQ-1:0] win_gnt;
   logic win_any, accept, done;
   logic [AW-1:0] cap_addr;
   logic [DW-1:0] cap_wdata;
   logic [2:0] cap_size;
   logic cap_write;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
      .req(req_valid), .ptr(rr), .gnt(win_gnt), .idx(win_idx), .any(win_any)
   );

   assign accept = (state == ST_IDLE) && win_any;
   assign done   = (state == ST_DATA) && HREADYOUT;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else state <= state_nxt;
   end

   always_comb begin
      state_nxt = (state == ST_IDLE) ? (win_any ? ST_ADDR : ST_IDLE) :
                  (state == ST_ADDR) ? (HREADYOUT ? ST_DATA : ST_ADDR) :
                  (state == ST_DATA) ? (HREADYOUT ? ST_IDLE : ST_DATA) : ST_IDLE;
   end

   always_comb begin
      req_ready = (state == ST_IDLE) ? win_gnt : '0;
      HSEL      = (state == ST_ADDR);
      HTRANS    = (state == ST_ADDR) ? HT_NONSEQ : HT_IDLE;
      HADDR     = cap_addr;
      HWRITE    = cap_write;
      HSIZE     = cap_size;
      HWDATA    = cap_wdata;
      HBURST    = HBURST_SINGLE;
      HPROT     = HPROT_DEFAULT;
      HMASTLOCK = 1'b0;
   end

   // The winner becomes the new rr pointer so it is searched last next time.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr        <= IW'(NREQ - 1);
         owner     <= '0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_size  <= '0;
         cap_write <= 1'b0;
      end else if (accept) begin
         rr        <= win_idx;
         owner     <= win_idx;
         cap_addr  <= req_addr[int'(win_idx)*AW +: AW];
         cap_wdata <= req_wdata[int'(win_idx)*DW +: DW];
         cap_size  <= req_size[int'(win_idx)*3 +: 3];
         cap_write <= req_write[win_idx];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= done ? (NREQ'(1) << owner) : '0;
         if (done) begin
            rsp_rdata <= cap_write ? '0 : HRDATA;
            rsp_err   <= HRESP;
         end
      end
   end
endmodule

// File: tb/tb_ahb_req_arbiter.sv
// tb_ahb_req_arbiter: directed scenarios with hand-computed expectations for ahb_req_arbiter.
module tb_ahb_req_arbiter;
   logic clk = 1'b0;
   logic rstn = 1'b1;
   logic [3:0] req_valid, req_ready, req_write, rsp_valid;
   logic [127:0] req_addr, req_wdata;
   logic [11:0] req_size;
   logic [31:0] rsp_rdata, HADDR, HWDATA, HRDATA;
   logic rsp_err, HSEL, HWRITE, HMASTLOCK, HREADYOUT, HRESP;
   logic [2:0] HSIZE, HBURST;
   logic [3:0] HPROT;
   logic [1:0] HTRANS;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ahb_req_arbiter #(.NREQ(4), .AW(32), .DW(32)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
      .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
   );

   task automatic clear_inputs;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_size = '0;
      HREADYOUT = 1'b1; HRESP = 1'b0; HRDATA = '0;
   endtask

   task automatic do_reset;
      clear_inputs();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
      req_valid[i] = 1'b1; req_write[i] = w;
      req_addr[i*32 +: 32] = a; req_wdata[i*32 +: 32] = d; req_size[i*3 +: 3] = s;
   endtask

   task automatic test_reset;
      clear_inputs();
      #2 rstn = 1'b0;
      #1;
      checks++; if (HTRANS !== 2'b00) begin failures++; $display("FAIL rst_htrans got=%h exp=0", HTRANS); end
      checks++; if (HSEL !== 1'b0) begin failures++; $display("FAIL rst_hsel got=%b exp=0", HSEL); end
      checks++; if (HADDR !== 32'h0 || HWDATA !== 32'h0) begin failures++; $display("FAIL rst_haddr_hwdata got=%h/%h exp=0/0", HADDR, HWDATA); end
      checks++; if (HWRITE !== 1'b0 || HSIZE !== 3'd0) begin failures++; $display("FAIL rst_hwrite_hsize got=%b/%h exp=0/0", HWRITE, HSIZE); end
      checks++; if (req_ready !== 4'h0 || rsp_valid !== 4'h0) begin failures++; $display("FAIL rst_ready_rsp got=%h/%h exp=0/0", req_ready, rsp_valid); end
      checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rdata_err got=%h/%b exp=0/0", rsp_rdata, rsp_err); end
      checks++; if (HBURST !== 3'b000 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0) begin failures++; $display("FAIL rst_consts got=%h/%h/%b exp=0/3/0", HBURST, HPROT, HMASTLOCK); end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_write;
      set_req(0, 1'b1, 32'h100, 32'hDEADBEEF, 3'd2);
      #1;
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL wr_ready got=%b exp=0001", req_ready); end
      @(negedge clk);
      req_valid = '0;
      checks++; if (HTRANS !== 2'b10 || HSEL !== 1'b1) begin failures++; $display("FAIL wr_addr_phase got=%h/%b exp=2/1", HTRANS, HSEL); end
      checks++; if (HADDR !== 32'h100 || HWRITE !== 1'b1 || HSIZE !== 3'd2) begin failures++; $display("FAIL wr_addr_fields got=%h/%b/%h exp=100/1/2", HADDR, HWRITE, HSIZE); end
      checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL wr_ready_busy got=%b exp=0000", req_ready); end
      @(negedge clk);
      checks++; if (HTRANS !== 2'b00 || HSEL !== 1'b0) begin failures++; $display("FAIL wr_data_htrans got=%h/%b exp=0/0", HTRANS, HSEL); end
      checks++; if (HWDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_hwdata got=%h exp=deadbeef", HWDATA); end
      checks++; if (rsp_valid !== 4'h0) begin failures++; $display("FAIL wr_rsp_early got=%b exp=0000", rsp_valid); end
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0) begin failures++; $display("FAIL wr_rsp got=%b/%b exp=0001/0", rsp_valid, rsp_err); end
      @(negedge clk);
      checks++; if (rsp_valid !== 4'h0) begin failures++; $display("FAIL wr_rsp_pulse got=%b exp=0000", rsp_valid); end
   endtask

   task automatic test_round_robin;
      logic [3:0] vv [10] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h6, 4'h6, 4'h6, 4'h9, 4'h9};
      logic [3:0] eg [10] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h2, 4'h8, 4'h1};
      do_reset();
      HRDATA = 32'h0BADF00D;
      for (int i = 0; i < 10; i++) begin
         req_valid = vv[i];
         #1;
         checks++; if (req_ready !== eg[i]) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, req_ready, eg[i]); end
         @(negedge clk);
         req_valid = '0;
         repeat (2) @(negedge clk);
         checks++; if (rsp_valid !== eg[i]) begin failures++; $display("FAIL rr_rsp[%0d] got=%b exp=%b", i, rsp_valid, eg[i]); end
      end
      @(negedge clk);
   endtask

   task automatic test_wait_states;
      do_reset();
      set_req(0, 1'b0, 32'h200, 32'hA5A5A5A5, 3'd2);
      @(negedge clk);
      req_valid = '0;
      req_wdata = '0;
      req_addr = '0;
      checks++; if (HADDR !== 32'h200 || HTRANS !== 2'b10) begin failures++; $display("FAIL ws_addr got=%h/%h exp=200/2", HADDR, HTRANS); end
      @(negedge clk);
      HREADYOUT = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (HWDATA !== 32'hA5A5A5A5 || HADDR !== 32'h200) begin failures++; $display("FAIL ws_stable got=%h/%h exp=a5a5a5a5/200", HWDATA, HADDR); end
      checks++; if (HTRANS !== 2'b00 || rsp_valid !== 4'h0) begin failures++; $display("FAIL ws_wait got=%h/%b exp=0/0000", HTRANS, rsp_valid); end
      @(negedge clk);
      checks++; if (rsp_valid !== 4'h0) begin failures++; $display("FAIL ws_rsp_early got=%b exp=0000", rsp_valid); end
      HREADYOUT = 1'b1;
      HRDATA = 32'h12345678;
      @(negedge clk);
      HRDATA = 32'h0;
      checks++; if (rsp_valid !== 4'b0001 || rsp_rdata !== 32'h12345678) begin failures++; $display("FAIL ws_rsp got=%b/%h exp=0001/12345678", rsp_valid, rsp_rdata); end
      @(negedge clk);
   endtask

   task automatic test_error;
      do_reset();
      set_req(1, 1'b1, 32'h300, 32'h11112222, 3'd2);
      #1;
      checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL err_ready got=%b exp=0010", req_ready); end
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      HRESP = 1'b1; HREADYOUT = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid !== 4'h0) begin failures++; $display("FAIL err_first_cycle got=%b exp=0000", rsp_valid); end
      HREADYOUT = 1'b1;
      @(negedge clk);
      HRESP = 1'b0;
      checks++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1) begin failures++; $display("FAIL err_rsp got=%b/%b exp=0010/1", rsp_valid, rsp_err); end
      HRDATA = 32'hCAFEF00D;
      set_req(0, 1'b0, 32'h400, 32'h0, 3'd2);
      #1;
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL err_next_ready got=%b exp=0001", req_ready); end
      @(negedge clk);
      req_valid = '0;
      checks++; if (HADDR !== 32'h400 || HTRANS !== 2'b10) begin failures++; $display("FAIL err_next_addr got=%h/%h exp=400/2", HADDR, HTRANS); end
      repeat (2) @(negedge clk);
      checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL err_next_rsp got=%b/%b/%h exp=0001/0/cafef00d", rsp_valid, rsp_err, rsp_rdata); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      logic seen = 1'b0;
      do_reset();
      set_req(0, 1'b1, 32'h500, 32'h55AA55AA, 3'd2);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      HREADYOUT = 1'b0;
      @(negedge clk);
      rstn = 1'b0;
      #1;
      checks++; if (HTRANS !== 2'b00 || HSEL !== 1'b0 || HWDATA !== 32'h0) begin failures++; $display("FAIL mid_rst_outputs got=%h/%b/%h exp=0/0/0", HTRANS, HSEL, HWDATA); end
      HREADYOUT = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 2) rstn = 1'b1;
         if (rsp_valid !== 4'h0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_rst_rsp got=1 exp=0"); end
      req_valid = 4'hF;
      #1;
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_rst_rr got=%b exp=0001", req_ready); end
      req_valid = '0;
      @(negedge clk);
   endtask

   task automatic test_idle;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++; if (HTRANS !== 2'b00 || HSEL !== 1'b0 || req_ready !== 4'h0) begin failures++; $display("FAIL idle[%0d] got=%h/%b/%b exp=0/0/0000", i, HTRANS, HSEL, req_ready); end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_round_robin();
      test_wait_states();
      test_error();
      test_reset_mid();
      test_idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
